// File: rtl/config_pkg.sv
// config_pkg: core configuration record shared by front-end blocks.
package config_pkg;
  typedef struct packed {
    int unsigned INSTR_PER_FETCH;
    int unsigned ILEN;
    int unsigned VLEN;
  } cfg_t;
  localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 1, ILEN: 32, VLEN: 32};
endpackage

// File: rtl/ibuffer_pkg.sv
// ibuffer_pkg: constants and helpers shared by the instruction buffer files.
package ibuffer_pkg;
  localparam int unsigned PC_STEP = 4;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/ibuffer_compact.sv
// ibuffer_compact: per-slot prefix-sum write offsets, slot PCs and valid count of a fetch group.
module ibuffer_compact
  import config_pkg::*, ibuffer_pkg::*;
#(
  parameter cfg_t Cfg = EmptyCfg,
  parameter int   OW  = cnt_w(int'(Cfg.INSTR_PER_FETCH))
) (
  input  logic [Cfg.INSTR_PER_FETCH-1:0]                  i_mask,
  input  logic [Cfg.VLEN-1:0]                             i_pc,
  output logic [Cfg.INSTR_PER_FETCH-1:0][OW-1:0]          o_off,
  output logic [Cfg.INSTR_PER_FETCH-1:0][Cfg.VLEN-1:0]    o_pc,
  output logic [OW-1:0]                                   o_n
);
  localparam int unsigned VW = Cfg.VLEN;
  always_comb begin
    o_n   = '0;
    o_off = '0;
    o_pc  = '0;
    for (int i = 0; i < int'(Cfg.INSTR_PER_FETCH); i++) begin
      o_off[i] = o_n;
      o_pc[i]  = i_pc + VW'(PC_STEP * i);
      o_n      = o_n + OW'(i_mask[i]);
    end
  end
endmodule

// File: rtl/ibuffer.sv
// ibuffer: compacting circular instruction queue between fetch and decode.
module ibuffer
  import config_pkg::*, ibuffer_pkg::*;
#(
  parameter cfg_t        Cfg       = EmptyCfg,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DEC_WIDTH = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           flush_i,
  input  logic                                           fe_valid_i,
  output logic                                           fe_ready_o,
  input  logic [Cfg.VLEN-1:0]                            fe_pc_i,
  input  logic [Cfg.INSTR_PER_FETCH-1:0]                 fe_slot_valid_i,
  input  logic [Cfg.INSTR_PER_FETCH-1:0][Cfg.ILEN-1:0]   fe_instr_i,
  output logic [DEC_WIDTH-1:0]                           de_valid_o,
  output logic [DEC_WIDTH-1:0][Cfg.ILEN-1:0]             de_instr_o,
  output logic [DEC_WIDTH-1:0][Cfg.VLEN-1:0]             de_pc_o,
  input  logic                                           de_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]                     count_o
);
  localparam int unsigned IPF = Cfg.INSTR_PER_FETCH;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = cnt_w(int'(IPF));
  typedef struct packed {
    logic [Cfg.ILEN-1:0] instr;
    logic [Cfg.VLEN-1:0] pc;
  } entry_t;
  entry_t                          r_mem [DEPTH];
  logic [IW-1:0]                   r_head, r_tail;
  logic [CW-1:0]                   r_count, w_m;
  logic [IPF-1:0][OW-1:0]          w_off;
  logic [IPF-1:0][Cfg.VLEN-1:0]    w_pc;
  logic [OW-1:0]                   w_n;
  logic                            w_push, w_pop;
  ibuffer_compact #(.Cfg(Cfg), .OW(OW)) u_compact (
    .i_mask (fe_slot_valid_i),
    .i_pc   (fe_pc_i),
    .o_off  (w_off),
    .o_pc   (w_pc),
    .o_n    (w_n)
  );
  // Ready looks only at registered occupancy, so a same-cycle pop never opens the door.
  assign fe_ready_o = r_count <= CW'(DEPTH - IPF);
  assign w_push     = fe_valid_i && fe_ready_o && !flush_i;
  assign w_pop      = de_ready_i && de_valid_o[0] && !flush_i;
  assign w_m        = r_count < CW'(DEC_WIDTH) ? r_count : CW'(DEC_WIDTH);
  assign count_o    = r_count;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_pop ? r_head + IW'(w_m) : r_head;
      r_tail  <= w_push ? r_tail + IW'(w_n) : r_tail;
      r_count <= r_count + (w_push ? CW'(w_n) : '0) - (w_pop ? w_m : '0);
    end
  end
  // Storage is deliberately left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(IPF); i++)
      if (w_push && fe_slot_valid_i[i])
        r_mem[r_tail + IW'(w_off[i])] <= '{instr: fe_instr_i[i], pc: w_pc[i]};
  end
  for (genvar k = 0; k < int'(DEC_WIDTH); k++) begin : g_de
    assign de_valid_o[k] = CW'(k) < r_count;
    assign de_instr_o[k] = r_mem[r_head + IW'(k)].instr;
    assign de_pc_o[k]    = r_mem[r_head + IW'(k)].pc;
  end
endmodule

// File: tb/tb_ibuffer.sv
// tb_ibuffer: randomized and directed checks of ibuffer against a queue-based model.
module tb_ibuffer;
  import config_pkg::*;
  localparam cfg_t CFG = '{INSTR_PER_FETCH: 4, ILEN: 32, VLEN: 32};
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  logic             clk = 0, rst_n = 0, flush = 0, fe_valid = 0, fe_ready, de_ready = 0;
  logic [31:0]      fe_pc = '0;
  logic [3:0]       fe_mask = '0;
  logic [3:0][31:0] fe_instr = '0;
  logic [1:0]       de_valid;
  logic [1:0][31:0] de_instr, de_pc;
  logic [3:0]       count;
  ent_t             q[$];
  int               n_chk = 0, n_pass = 0, pushed = 0;
  always #5 clk = ~clk;
  ibuffer #(.Cfg(CFG), .DEPTH(8), .DEC_WIDTH(2)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .fe_valid_i      (fe_valid),
    .fe_ready_o      (fe_ready),
    .fe_pc_i         (fe_pc),
    .fe_slot_valid_i (fe_mask),
    .fe_instr_i      (fe_instr),
    .de_valid_o      (de_valid),
    .de_instr_o      (de_instr),
    .de_pc_o         (de_pc),
    .de_ready_i      (de_ready),
    .count_o         (count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic expect_state();
    check("count", 64'(count), 64'(q.size()));
    check("ready", 64'(fe_ready), 64'((8 - q.size()) >= 4));
    for (int k = 0; k < 2; k++) begin
      check("valid", 64'(de_valid[k]), 64'(k < q.size()));
      if (k < q.size()) begin
        check("instr", 64'(de_instr[k]), 64'(q[k].instr));
        check("pc", 64'(de_pc[k]), 64'(q[k].pc));
      end
    end
  endtask
  // One clock: drive, compare against the model, clock, then advance the model.
  task automatic cyc(input bit fv, input logic [3:0] mask, input logic [31:0] pc,
                     input bit rdy, input bit fl);
    int  m;
    bit  ok;
    fe_valid = fv;
    fe_mask  = mask;
    fe_pc    = pc;
    de_ready = rdy;
    flush    = fl;
    #1;
    expect_state();
    ok = (8 - q.size()) >= 4;
    m  = q.size() < 2 ? q.size() : 2;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (rdy) repeat (m) q.delete(0);
      if (fv && ok)
        for (int i = 0; i < 4; i++)
          if (mask[i]) q.push_back('{fe_instr[i], pc + 32'(4 * i)});
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    check("rst_valid", 64'(de_valid), 64'(0));
    check("rst_ready", 64'(fe_ready), 64'(1));
    check("rst_count", 64'(count), 64'(0));
    fe_instr = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    cyc(1, 4'b1010, 32'h8000_0000, 0, 0);
    check("cmp_valid", 64'(de_valid), 64'(2'b11));
    check("cmp_i0", 64'(de_instr[0]), 64'(32'hBBBB_0001));
    check("cmp_pc0", 64'(de_pc[0]), 64'(32'h8000_0004));
    check("cmp_i1", 64'(de_instr[1]), 64'(32'hDDDD_0003));
    check("cmp_pc1", 64'(de_pc[1]), 64'(32'h8000_000C));
    cyc(0, 4'h0, 32'h0, 0, 1);
    cyc(1, 4'hF, 32'h1000, 0, 0);
    cyc(1, 4'b0001, 32'h2000, 0, 0);
    check("bp_full", 64'(fe_ready), 64'(0));
    check("bp_count5", 64'(count), 64'(5));
    cyc(0, 4'h0, 32'h0, 1, 0);
    check("bp_reopen", 64'(fe_ready), 64'(1));
    check("bp_count3", 64'(count), 64'(3));
    cyc(0, 4'h0, 32'h0, 0, 1);
    for (int c = 0; c < 400 && pushed < 40; c++) begin
      for (int i = 0; i < 4; i++) fe_instr[i] = $urandom;
      fe_mask  = 4'($urandom);
      fe_valid = 1'($urandom_range(0, 3) != 0);
      if (fe_valid && (8 - q.size()) >= 4) pushed += $countones(fe_mask);
      cyc(fe_valid, fe_mask, $urandom, 1'($urandom), 0);
    end
    check("stream_len", 64'(pushed >= 40), 64'(1));
    repeat (6) cyc(0, 4'h0, 32'h0, 1, 0);
    check("drained", 64'(count), 64'(0));
    cyc(1, 4'hF, 32'h3000, 0, 0);
    cyc(1, 4'b0011, 32'h4000, 0, 0);
    check("fl_count6", 64'(count), 64'(6));
    cyc(1, 4'hF, 32'h5000, 1, 1);
    check("fl_count", 64'(count), 64'(0));
    check("fl_valid", 64'(de_valid), 64'(0));
    cyc(1, 4'hF, 32'hFFFF_FFF8, 0, 0);
    check("pcw_0", 64'(de_pc[0]), 64'(32'hFFFF_FFF8));
    check("pcw_1", 64'(de_pc[1]), 64'(32'hFFFF_FFFC));
    cyc(0, 4'h0, 32'h0, 1, 0);
    check("pcw_2", 64'(de_pc[0]), 64'(32'h0000_0000));
    check("pcw_3", 64'(de_pc[1]), 64'(32'h0000_0004));
    cyc(1, 4'hF, 32'h6000, 0, 0);
    fe_valid = 0;
    rst_n = 0;
    #2;
    q.delete();
    check("arst_count", 64'(count), 64'(0));
    check("arst_valid", 64'(de_valid), 64'(0));
    check("arst_ready", 64'(fe_ready), 64'(1));
    rst_n = 1;
    cyc(0, 4'h0, 32'h0, 1, 0);
    cyc(1, 4'b0110, 32'h7000, 0, 0);
    cyc(0, 4'h0, 32'h0, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
